// File: rtl/i2c_target_regbank.sv
// I2C target giving a bus controller register-mapped access to a host-side
// bank of NUM_REGS 8-bit registers. SCL/SDA are synchronised and glitch
// filtered; START/STOP are detected in any state; the register pointer
// auto-increments (with wrap) across burst reads and writes.
//
// Register-side interface: reg_addr always presents the current pointer.
// reg_rdata must reflect reg_addr one clk after it changes; it is only
// sampled on an SCL falling edge, long after the pointer last moved.
// reg_wr is a single-clk strobe with no back-pressure: reg_wdata and
// reg_addr are valid in exactly the clk where reg_wr=1, and the bank must
// accept the write in that clk.
module i2c_target_regbank #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = 4,
    parameter int         FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic [PTR_W-1:0] reg_addr,
    input  logic [7:0]       reg_rdata,
    output logic             reg_wr,
    output logic [7:0]       reg_wdata,
    output logic             busy,
    output logic             start_det,
    output logic             stop_det
);

    // Protocol states. IDLE and WAIT both ignore the bus except START/STOP;
    // WAIT marks "transaction abandoned" (NACKed pointer or read end).
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ADDR     = 4'd1;
    localparam logic [3:0] ADDR_ACK = 4'd2;
    localparam logic [3:0] PTR      = 4'd3;
    localparam logic [3:0] PTR_ACK  = 4'd4;
    localparam logic [3:0] WR_DATA  = 4'd5;
    localparam logic [3:0] WR_ACK   = 4'd6;
    localparam logic [3:0] RD_DATA  = 4'd7;
    localparam logic [3:0] RD_ACK   = 4'd8;
    localparam logic [3:0] WAIT     = 4'd9;

    // Filter counter counts 0..FILT_LEN-1 disagreeing samples.
    localparam int              FC_W   = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILT_LEN - 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REGS - 1);
    localparam logic [8:0]       REG_LIM  = 9'(NUM_REGS);

    // Input conditioning
    logic            scl_s1, scl_s2, sda_s1, sda_s2;
    logic            scl_f, sda_f, scl_f_d, sda_f_d;
    logic [FC_W-1:0] scl_cnt, sda_cnt;

    // Protocol engine (state and bit_cnt are the observable FSM status)
    logic [3:0]       state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             rw;
    logic [PTR_W-1:0] ptr;

    logic             scl_rise, scl_fall;
    logic             start_cond, stop_cond;
    logic [7:0]       shift_in;
    logic [PTR_W-1:0] ptr_inc;
    logic             ptr_ok;

    assign reg_addr = ptr;

    // Edge pulses and bus conditions, all on the filtered levels. SCL must
    // have been high for at least one full clk so a coincident SCL/SDA
    // change cannot masquerade as START or STOP.
    assign scl_rise   = scl_f & ~scl_f_d;
    assign scl_fall   = ~scl_f & scl_f_d;
    assign start_cond = scl_f & scl_f_d & sda_f_d & ~sda_f;
    assign stop_cond  = scl_f & scl_f_d & ~sda_f_d & sda_f;

    // Byte value as it will look once the current SDA sample is shifted in.
    assign shift_in = {shift[6:0], sda_f};
    assign ptr_ok   = ({1'b0, shift_in} < REG_LIM);
    assign ptr_inc  = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
        end
    end

    // SCL stability filter: level follows input only after FILT_LEN equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_f   <= 1'b1;
            scl_cnt <= '0;
        end else if (scl_s2 == scl_f) begin
            scl_cnt <= '0;
        end else if (scl_cnt == FC_MAX) begin
            scl_f   <= scl_s2;
            scl_cnt <= '0;
        end else begin
            scl_cnt <= scl_cnt + 1'b1;
        end
    end

    // SDA stability filter, same rule as SCL.
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_f   <= 1'b1;
            sda_cnt <= '0;
        end else if (sda_s2 == sda_f) begin
            sda_cnt <= '0;
        end else if (sda_cnt == FC_MAX) begin
            sda_f   <= sda_s2;
            sda_cnt <= '0;
        end else begin
            sda_cnt <= sda_cnt + 1'b1;
        end
    end

    // Previous filtered levels for edge and bus-condition detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_f_d <= 1'b1;
            sda_f_d <= 1'b1;
        end else begin
            scl_f_d <= scl_f;
            sda_f_d <= sda_f;
        end
    end

    // Protocol FSM: STOP/START override everything, otherwise bits are
    // sampled on scl_rise and SDA drive changes only on scl_fall. In the
    // ACK states bit_cnt doubles as a phase flag (0 = before ACK, 1 = during).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            busy      <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            reg_wr    <= 1'b0;
            if (stop_cond) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                stop_det <= 1'b1;
            end else if (start_cond) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                start_det <= 1'b1;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= shift_in;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                if (shift_in[7:1] == DEV_ADDR) begin
                                    state <= ADDR_ACK;
                                    rw    <= shift_in[0];
                                    busy  <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe  <= 1'b1;
                                bit_cnt <= 3'd1;
                            end else begin
                                bit_cnt <= '0;
                                if (rw) begin
                                    // First read bit goes out on this same fall.
                                    state  <= RD_DATA;
                                    sda_oe <= ~reg_rdata[7];
                                    shift  <= {reg_rdata[6:0], 1'b0};
                                end else begin
                                    state  <= PTR;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shift <= shift_in;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                if (ptr_ok) begin
                                    ptr   <= shift_in[PTR_W-1:0];
                                    state <= PTR_ACK;
                                end else begin
                                    // Out-of-range pointer: no ACK, abandon transaction.
                                    state <= WAIT;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    PTR_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe  <= 1'b1;
                                bit_cnt <= 3'd1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift <= shift_in;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt   <= '0;
                                reg_wr    <= 1'b1;
                                reg_wdata <= shift_in;
                                state     <= WR_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe  <= 1'b1;
                                bit_cnt <= 3'd1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                ptr     <= ptr_inc;
                                state   <= WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RD_ACK;
                            end else begin
                                sda_oe  <= ~shift[7];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (bit_cnt == 3'd0) begin
                            if (scl_rise) begin
                                if (!sda_f) begin
                                    ptr     <= ptr_inc;
                                    bit_cnt <= 3'd1;
                                end else begin
                                    // Controller NACK ends the read; SDA already released.
                                    state <= WAIT;
                                end
                            end
                        end else if (scl_fall) begin
                            // reg_rdata has settled for the incremented pointer by now.
                            state   <= RD_DATA;
                            bit_cnt <= '0;
                            sda_oe  <= ~reg_rdata[7];
                            shift   <= {reg_rdata[6:0], 1'b0};
                        end
                    end
                    default: begin
                        // IDLE / WAIT: only START or STOP move the FSM.
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Directed bench for i2c_target_regbank: a bit-banged I2C controller with an
// open-drain bus model, a register bank model and a write scoreboard.
module tb_i2c_target_regbank;

    localparam int Q = 10;  // quarter SCL period in clks (SCL = clk/40)

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Bus and register-side signals
    logic       scl_ctrl, sda_ctrl, sda_bus;
    logic       sda_oe;
    logic [3:0] reg_addr;
    logic [7:0] reg_rdata;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic       busy, start_det, stop_det;
    logic [7:0] regs [16];

    assign sda_bus   = sda_ctrl & ~sda_oe;
    assign reg_rdata = regs[reg_addr];

    i2c_target_regbank dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_ctrl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Scoreboard state
    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    logic [11:0] wr_q[$];
    int          start_cnt = 0;
    int          stop_cnt  = 0;
    int          oe_cnt    = 0;

    // Monitor: log writes and count pulses / SDA drive clks
    always @(negedge clk) begin
        if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
        if (sda_oe) oe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_wr_count"}, wr_q.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_q.size() > 0)
            check_eq({tag, "_wr"}, wr_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        wr_q.delete();
    endtask

    // Driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_ctrl = b;
        wait_clks(Q);
        scl_ctrl = 1'b1;
        wait_clks(Q);
        s = sda_bus;
        wait_clks(Q);
        scl_ctrl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1;
        wait_clks(Q);
        scl_ctrl = 1'b1;
        wait_clks(Q);
        sda_ctrl = 1'b0;
        wait_clks(Q);
        scl_ctrl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0;
        wait_clks(Q);
        scl_ctrl = 1'b1;
        wait_clks(Q);
        sda_ctrl = 1'b1;
        wait_clks(2 * Q);
    endtask

    task automatic scl_glitch();
        scl_ctrl = 1'b1;
        wait_clks(1);
        scl_ctrl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_after, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], s);
            if (i == glitch_after) scl_glitch();
        end
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(nack, s);
    endtask

    // Stimulus and checks
    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        int         s0, p0, o0;

        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        rst      = 1'b1;
        scl_ctrl = 1'b1;
        sda_ctrl = 1'b1;
        wait_clks(5);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_reg_wr", reg_wr, 0);
        check_eq("rst_reg_wdata", reg_wdata, 0);
        check_eq("rst_reg_addr", reg_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_start_det", start_det, 0);
        check_eq("rst_stop_det", stop_det, 0);
        rst = 1'b0;
        wait_clks(10);

        // Burst write of two registers starting at 3
        s0 = start_cnt;
        p0 = stop_cnt;
        i2c_start();
        write_byte(8'h84, -1, ack); check_eq("t1_addr_ack", ack, 1);
        write_byte(8'h03, -1, ack); check_eq("t1_ptr_ack", ack, 1);
        write_byte(8'hA5, -1, ack); check_eq("t1_d0_ack", ack, 1);
        write_byte(8'h5A, -1, ack); check_eq("t1_d1_ack", ack, 1);
        check_eq("t1_busy_mid", busy, 1);
        i2c_stop();
        exp_q.push_back({4'd3, 8'hA5});
        exp_q.push_back({4'd4, 8'h5A});
        check_writes("t1");
        check_eq("t1_start_cnt", start_cnt - s0, 1);
        check_eq("t1_stop_cnt", stop_cnt - p0, 1);
        check_eq("t1_busy_end", busy, 0);
        check_eq("t1_ptr_end", reg_addr, 5);

        // Pointer wrap from 15 to 0
        i2c_start();
        write_byte(8'h84, -1, ack); check_eq("t2_addr_ack", ack, 1);
        write_byte(8'h0F, -1, ack); check_eq("t2_ptr_ack", ack, 1);
        write_byte(8'h11, -1, ack); check_eq("t2_d0_ack", ack, 1);
        write_byte(8'h22, -1, ack); check_eq("t2_d1_ack", ack, 1);
        i2c_stop();
        exp_q.push_back({4'd15, 8'h11});
        exp_q.push_back({4'd0, 8'h22});
        check_writes("t2");
        check_eq("t2_ptr_end", reg_addr, 1);

        // Set pointer, repeated START, burst read of three registers
        regs[2] = 8'hC3;
        regs[3] = 8'h3C;
        regs[4] = 8'h99;
        s0 = start_cnt;
        i2c_start();
        write_byte(8'h84, -1, ack); check_eq("t3_addr_ack", ack, 1);
        write_byte(8'h02, -1, ack); check_eq("t3_ptr_ack", ack, 1);
        i2c_start();
        write_byte(8'h85, -1, ack); check_eq("t3_raddr_ack", ack, 1);
        read_byte(1'b0, d); check_eq("t3_rd0", d, 8'hC3);
        read_byte(1'b0, d); check_eq("t3_rd1", d, 8'h3C);
        read_byte(1'b1, d); check_eq("t3_rd2", d, 8'h99);
        o0 = oe_cnt;
        read_byte(1'b1, d); check_eq("t3_after_nack_bus", d, 8'hFF);
        check_eq("t3_after_nack_oe", oe_cnt - o0, 0);
        i2c_stop();
        check_eq("t3_start_cnt", start_cnt - s0, 2);
        check_writes("t3");
        check_eq("t3_ptr_end", reg_addr, 4);
        check_eq("t3_busy_end", busy, 0);

        // Wrong device address: silent
        o0 = oe_cnt;
        i2c_start();
        write_byte(8'h86, -1, ack); check_eq("t4_addr_nack", ack, 0);
        check_eq("t4_busy", busy, 0);
        i2c_stop();
        check_eq("t4_oe_clks", oe_cnt - o0, 0);
        check_writes("t4");

        // Out-of-range pointer: NACK, following data ignored
        i2c_start();
        write_byte(8'h84, -1, ack); check_eq("t5_addr_ack", ack, 1);
        write_byte(8'h10, -1, ack); check_eq("t5_ptr_nack", ack, 0);
        check_eq("t5_ptr_kept", reg_addr, 4);
        write_byte(8'h55, -1, ack); check_eq("t5_data_nack", ack, 0);
        i2c_stop();
        check_writes("t5");
        check_eq("t5_ptr_end", reg_addr, 4);

        // One-clk SCL glitches between bits must not count as clocks
        i2c_start();
        write_byte(8'h84, 4, ack); check_eq("t6_addr_ack", ack, 1);
        write_byte(8'h05, -1, ack); check_eq("t6_ptr_ack", ack, 1);
        write_byte(8'h77, 2, ack); check_eq("t6_d0_ack", ack, 1);
        i2c_stop();
        exp_q.push_back({4'd5, 8'h77});
        check_writes("t6");

        // Reset in the middle of read bit 4 (a driven 0 of 0xC3)
        i2c_start();
        write_byte(8'h84, -1, ack); check_eq("t7_addr_ack", ack, 1);
        write_byte(8'h02, -1, ack); check_eq("t7_ptr_ack", ack, 1);
        i2c_start();
        write_byte(8'h85, -1, ack); check_eq("t7_raddr_ack", ack, 1);
        send_bit(1'b1, s); check_eq("t7_bit1", s, 1);
        send_bit(1'b1, s); check_eq("t7_bit2", s, 1);
        send_bit(1'b1, s); check_eq("t7_bit3", s, 0);
        sda_ctrl = 1'b1;
        wait_clks(Q);
        scl_ctrl = 1'b1;
        wait_clks(Q);
        check_eq("t7_drive_bit4", sda_oe, 1);
        rst = 1'b1;
        wait_clks(1);
        check_eq("t7_rst_oe", sda_oe, 0);
        check_eq("t7_rst_busy", busy, 0);
        check_eq("t7_rst_ptr", reg_addr, 0);
        rst = 1'b0;
        scl_ctrl = 1'b0;
        wait_clks(Q);
        scl_ctrl = 1'b1;
        wait_clks(2 * Q);
        i2c_start();
        write_byte(8'h84, -1, ack); check_eq("t7_post_addr_ack", ack, 1);
        write_byte(8'h06, -1, ack); check_eq("t7_post_ptr_ack", ack, 1);
        write_byte(8'hE7, -1, ack); check_eq("t7_post_d0_ack", ack, 1);
        i2c_stop();
        exp_q.push_back({4'd6, 8'hE7});
        check_writes("t7");
        check_eq("t7_busy_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
